// File: rtl/fadd_rr_scheduler.sv
// Round-robin sharing of one combinational FP32 adder among NREQ requesters,
// with a two-deep registered pipeline (operands -> sum) and a backpressured response port.

module IEEE32float_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  logic [31:0] big, sml;
  logic [7:0]  big_e, sml_e, d_e;
  logic [26:0] big_m, sml_m, norm;
  logic [27:0] mag;
  logic [8:0]  res_e;
  logic [4:0]  lz;
  logic        flush, a_nan, b_nan, a_inf, b_inf;

  assign a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
  assign b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
  assign a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
  assign b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);

  always_comb begin
    big = a_i;
    sml = b_i;
    if (b_i[30:0] > a_i[30:0]) begin
      big = b_i;
      sml = a_i;
    end
    // Denormals use exponent 1 with no hidden bit; three extra low bits for alignment.
    big_e = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    sml_e = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    big_m = {big[30:23] != 8'd0, big[22:0], 3'b000};
    sml_m = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    d_e   = big_e - sml_e;
    sml_m = (d_e > 8'd26) ? 27'd0 : (sml_m >> d_e);
    mag   = (big[31] == sml[31]) ? ({1'b0, big_m} + {1'b0, sml_m})
                                 : ({1'b0, big_m} - {1'b0, sml_m});
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (mag[i]) lz = 5'(26 - i);
    res_e = {1'b0, big_e};
    norm  = mag[26:0];
    flush = 1'b0;
    if (mag[27]) begin
      norm  = mag[27:1];
      res_e = res_e + 9'd1;
    end else if (res_e > {4'd0, lz}) begin
      norm  = mag[26:0] << lz;
      res_e = res_e - {4'd0, lz};
    end else begin
      flush = 1'b1;
    end

    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) sum_o = 32'hFFFF_FFFF;
    else if (a_inf)                       sum_o = a_i;
    else if (b_inf)                       sum_o = b_i;
    else if (mag == 28'd0 || flush)       sum_o = 32'd0;
    else if (res_e >= 9'd255)             sum_o = {big[31], 8'hFF, 23'd0};
    else                                  sum_o = {big[31], res_e[7:0], norm[25:3]};
  end
endmodule

module fadd_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_special,
  output logic              busy,
  output logic [31:0]       ops_done
);
  logic           s1_vld_q, s2_vld_q, s2_spec_q;
  logic [31:0]    s1_a_q, s1_b_q, s2_data_q, ops_q, sum;
  logic [IDW-1:0] s1_id_q, s2_id_q, rr_ptr_q, rr_ptr_d, gnt_id;
  logic           gnt_vld, grant, s1_adv, s2_adv;
  int             idx;

  assign s2_adv = !s2_vld_q | rsp_ready;
  assign s1_adv = !s1_vld_q | s2_adv;

  // Scan downward so the requester closest to rr_ptr (upward, modulo NREQ) wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[IDW-1:0];
      end
    end
  end

  assign grant     = gnt_vld & s1_adv;
  assign req_ready = grant ? (NREQ'(1) << gnt_id) : '0;
  assign rr_ptr_d  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  IEEE32float_adder u_add (.a_i(s1_a_q), .b_i(s1_b_q), .sum_o(sum));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_id_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_id_q   <= '0;
      s2_spec_q <= 1'b0;
      rr_ptr_q  <= '0;
      ops_q     <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld_q <= grant;
        if (grant) begin
          s1_a_q   <= req_a[32*gnt_id +: 32];
          s1_b_q   <= req_b[32*gnt_id +: 32];
          s1_id_q  <= gnt_id;
          rr_ptr_q <= rr_ptr_d;
        end
      end
      if (s2_adv) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_data_q <= sum;
          s2_id_q   <= s1_id_q;
          s2_spec_q <= (s1_a_q[30:23] == 8'hFF) | (s1_b_q[30:23] == 8'hFF);
        end
      end
      if (s2_vld_q & rsp_ready) ops_q <= ops_q + 32'd1;
    end
  end

  assign rsp_valid   = s2_vld_q;
  assign rsp_data    = s2_data_q;
  assign rsp_id      = s2_id_q;
  assign rsp_special = s2_spec_q;
  assign busy        = s1_vld_q | s2_vld_q;
  assign ops_done    = ops_q;
endmodule

// File: tb/tb_fadd_rr_scheduler.sv
// Directed bench for fadd_rr_scheduler: scoreboard of expected responses filled at
// each request handshake, drained at each response handshake.

module tb_fadd_rr_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [32*NREQ-1:0]   req_a, req_b;
  logic                 rsp_valid, rsp_ready, rsp_special, busy;
  logic [31:0]          rsp_data, ops_done;
  logic [IDW-1:0]       rsp_id;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    logic           spec;
  } rsp_t;

  rsp_t            sb[$];
  int              gseq[$];
  rsp_t            e;
  logic [31:0]     exp_sum [NREQ];
  logic            exp_spec[NREQ];
  logic            cont    [NREQ];
  logic [NREQ-1:0] last_gnt, prev_valid;
  logic            prev_stall;
  logic [31:0]     prev_data, exp_ops;
  logic [IDW-1:0]  prev_id;

  fadd_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_special(rsp_special),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Small positive integers are exact in FP32, so integer sums give reference results.
  function automatic logic [31:0] itof(input int v);
    int p;
    logic [31:0] m;
    p = 0;
    for (int i = 0; i < 24; i++) if (v[i]) p = i;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s, input logic sp);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    exp_sum[i]        = s;
    exp_spec[i]       = sp;
    req_valid[i]      = 1'b1;
  endtask

  task automatic rand_op(input int i);
    int x, y;
    x = $urandom_range(1, 4000);
    y = $urandom_range(1, 4000);
    set_op(i, itof(x), itof(y), itof(x + y), 1'b0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (last_gnt[i]) begin
        if (cont[i]) rand_op(i);
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && (req_valid != '0 || busy); n++) cycle();
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_sb", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: sample away from the active edge; inputs change at posedge+1.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      exp_ops    = '0;
      last_gnt   = '0;
      prev_valid = '0;
      prev_stall = 1'b0;
    end else begin
      chk("ops_done", ops_done, exp_ops);
      chk("req_onehot", 32'($onehot0(req_ready)), 32'd1);
      chk("req_hold", 32'(prev_valid & ~last_gnt & ~req_valid), 32'd0);
      if (prev_stall) begin
        chk("stall_data", rsp_data, prev_data);
        chk("stall_id", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_special", 32'(rsp_special), 32'(e.spec));
        end
        exp_ops = exp_ops + 32'd1;
      end
      last_gnt = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (last_gnt[i]) begin
          sb.push_back(rsp_t'{exp_sum[i], IDW'(i), exp_spec[i]});
          gseq.push_back(i);
        end
      end
      prev_valid = req_valid;
      prev_stall = rsp_valid & !rsp_ready;
      prev_data  = rsp_data;
      prev_id    = rsp_id;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cont[i] = 1'b0; exp_sum[i] = '0; exp_spec[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_special", 32'(rsp_special), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops_done", ops_done, 32'd0);
    reset     = 1'b0;
    rsp_ready = 1'b1;

    // Single op on port 2: 1.0 + 2.0, two-cycle latency.
    set_op(2, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    #1 chk("single_ready", 32'(req_ready), 32'h4);
    cycle();
    chk("single_c1_valid", 32'(rsp_valid), 32'd0);
    chk("single_c1_busy", 32'(busy), 32'd1);
    cycle();
    chk("single_c2_valid", 32'(rsp_valid), 32'd1);
    chk("single_c2_data", rsp_data, 32'h4040_0000);
    chk("single_c2_id", 32'(rsp_id), 32'd2);
    chk("single_c2_special", 32'(rsp_special), 32'd0);
    cycle();
    chk("single_ops_done", ops_done, 32'd1);
    chk("single_idle", 32'(busy), 32'd0);

    // Round-robin with all ports continuously requesting.
    do_reset();
    gseq.delete();
    for (int i = 0; i < NREQ; i++) begin cont[i] = 1'b1; rand_op(i); end
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k >= 1) chk("rr_rsp_every_cycle", 32'(rsp_valid), 32'd1);
    end
    chk("rr_grant_count", 32'(gseq.size() >= 8), 32'd1);
    if (gseq.size() >= 8)
      for (int k = 0; k < 8; k++) chk("rr_order", 32'(gseq[k]), 32'(k % NREQ));
    for (int i = 0; i < NREQ; i++) cont[i] = 1'b0;
    drain();

    // Backpressure: consumer stalls for 6 cycles.
    do_reset();
    gseq.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin cont[i] = 1'b1; rand_op(i); end
    for (int k = 0; k < 6; k++) cycle();
    chk("bp_grant_count", 32'(gseq.size()), 32'd2);
    if (gseq.size() >= 2) begin
      chk("bp_grant0", 32'(gseq[0]), 32'd0);
      chk("bp_grant1", 32'(gseq[1]), 32'd1);
    end
    chk("bp_ready_zero", 32'(req_ready), 32'd0);
    chk("bp_hold_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    #1 chk("bp_resume_port2", 32'(req_ready), 32'h4);
    cycle();
    chk("bp_next_id", 32'(rsp_id), 32'd1);
    for (int i = 0; i < NREQ; i++) cont[i] = 1'b0;
    drain();

    // Special operands and boundary sums.
    set_op(0, 32'h7F80_0000, 32'hFF80_0000, 32'hFFFF_FFFF, 1'b1);
    set_op(1, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b1);
    set_op(2, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0);
    set_op(3, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0);
    drain();
    set_op(0, 32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b1);
    set_op(1, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    set_op(2, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 1'b1);
    set_op(3, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b0);
    drain();

    // Reset with both stages full; port 1 keeps requesting across it.
    rsp_ready = 1'b0;
    cont[1] = 1'b1;
    rand_op(1); rand_op(2); rand_op(3);
    cycle();
    cycle();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    cycle();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_ops_done", ops_done, 32'd0);
    #1 chk("postrst_grant_low", 32'(req_ready), 32'h2);
    cont[1] = 1'b0;
    drain();

    // Completed-op counter wraps.
    force dut.ops_q = 32'hFFFF_FFFF;
    exp_ops = 32'hFFFF_FFFF;
    #1 release dut.ops_q;
    chk("wrap_preset", ops_done, 32'hFFFF_FFFF);
    set_op(0, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    drain();
    chk("wrap_ops_done", ops_done, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fadd_rr_scheduler.md
Name: fadd_rr_scheduler

Overview:
- Shares one instance of the team's combinational single-precision adder (IEEE32float_adder) among NREQ requesters.
- Round-robin arbitration, valid/ready handshake on each request port.
- Two-stage registered pipeline: operand register S1, then adder, then result register S2.
- Single shared response port with requester ID and backpressure. Sits between the vector/accumulate front-ends and the FP datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ), minimum 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_a  input  32*NREQ  operand A; requester i at bits [32i+31:32i].
- req_b  input  32*NREQ  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot (or zero) grant; handshake when req_valid[i] & req_ready[i].
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  32  IEEE-754 sum, bit-exact with the adder for the same operands.
- rsp_id  output  IDW  index of the requester that issued the operation.
- rsp_special  output  1  1 if either operand had exponent 8'hFF (Inf/NaN path).
- busy  output  1  S1 or S2 holds a valid entry.
- ops_done  output  32  count of completed response handshakes; wraps at 2^32.

Behaviour:
- Reset (synchronous, dominant over all other inputs):
  - S1/S2 valid = 0; rsp_valid = 0; rsp_data = 0; rsp_id = 0; rsp_special = 0.
  - ops_done = 0; rr_ptr = 0; busy = 0.
  - Any in-flight operation is discarded; no response is produced for it.
- Stall logic:
  - s2_adv = !s2_valid | rsp_ready.
  - s1_adv = !s1_valid | s2_adv.
- Grant (combinational):
  - If s1_adv = 1, grant the first i with req_valid[i] = 1, searching from rr_ptr upward modulo NREQ.
  - req_ready = one-hot of that i; otherwise req_ready = 0.
  - req_ready never depends on rsp_ready except through s1_adv and s2_adv.
- On a grant to i:
  - S1 <= {a_i, b_i, id = i}; s1_valid <= 1.
  - rr_ptr <= (i+1) mod NREQ.
  - With no grant: rr_ptr holds, and s1_valid <= 0 if s1_adv = 1.
- S1 to S2: when s1_adv & s1_valid:
  - S2 <= {adder(S1.a, S1.b), S1.id, special flag}; s2_valid <= 1.
  - When s2_adv & !s1_valid: s2_valid <= 0.
- Outputs:
  - rsp_valid = s2_valid; rsp_data, rsp_id, rsp_special come straight from the S2 registers.
  - While rsp_valid & !rsp_ready, S2 holds stable.
  - ops_done increments on rsp_valid & rsp_ready.
- Latency and throughput:
  - Grant at edge N gives rsp_valid high in the cycle after edge N+1 (2-cycle latency).
  - Full throughput is 1 op/cycle with rsp_ready held high.
  - Maximum 2 ops in flight.
- Backpressure: with rsp_ready low and S1 and S2 both full, req_ready = 0. No data is lost or duplicated.
- Simultaneous release: rsp handshake and new grant in the same cycle are both legal. S2 takes S1, and S1 takes the new operands.
- Requester rules:
  - req_valid must stay high with stable operands until granted.
  - Dropping valid early is a protocol violation; the bench asserts on it.
- Fairness: a continuously requesting port is granted within NREQ grants.
- Arithmetic: no rounding or special-case handling inside this block. Results are exactly those of the adder, including NaN = 32'hFFFF_FFFF and signed infinity.
- busy = s1_valid | s2_valid.

Test Plan:
- Single op: port 2 sends 3F80_0000 + 4000_0000 at cycle 0, rsp_ready = 1.
  - Expected: req_ready = 0100 in cycle 0; rsp_valid in cycle 2 with rsp_data = 4040_0000, rsp_id = 2, rsp_special = 0; ops_done = 1.
- Round-robin: all 4 ports valid continuously, rsp_ready = 1.
  - Expected: grant order 0,1,2,3,0,1,...; one response per cycle from cycle 2; rsp_id follows the same sequence.
- Backpressure: rsp_ready = 0 for 6 cycles with all ports valid.
  - Expected: exactly 2 grants (ports 0, 1), then req_ready = 0; rsp_data/rsp_id stay stable.
  - On release: responses for ids 0, 1 in order, then grants resume at port 2.
- Specials: 7F80_0000 + FF80_0000 -> rsp_data = FFFF_FFFF, rsp_special = 1; 7F80_0000 + 3F80_0000 -> 7F80_0000, rsp_special = 1.
- Reset mid-operation: assert reset for 1 cycle with S1 and S2 full.
  - Expected: next cycle rsp_valid = 0, busy = 0, ops_done = 0; following first grant goes to the lowest valid port.
- Counter wrap: force ops_done to FFFF_FFFF, complete 1 op -> ops_done = 0000_0000.
